parking_entry_ctrl: RTL

Gate arbitration stage of the smart-parking system. It sits directly upstream of the door blinker and drives its `open_signal` input. It debounces the entry and exit vehicle sensors and tracks lot occupancy against a fixed capacity. For each accepted car it issues a single-cycle `open_signal` pulse, and refuses entry when the lot is full. The door sequence downstream lasts 20 cycles (10 s at 2 Hz), so the block holds off new grants for that period.

---
 rtl/parking_entry_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/parking_entry_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : parking_entry_ctrl                                              |
// | Desc     : Entry/exit gate arbiter with sensor debounce, lot occupancy     |
// |            tracking and door-busy hold-off. Optional PARKING_PENDING_EN    |
// |            keeps one pending request per direction while the door is busy. |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module parking_entry_ctrl #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 20
) (
  input  logic             clk_2Hz,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic             open_signal,
  output logic             deny,
  output logic             busy,
  output logic             full,
  output logic [CNT_W-1:0] occupied,
  output logic [CNT_W-1:0] free_slots
);

  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    occ_q, occ_d;
  logic                entry_pend_q, entry_pend_d;
  logic                exit_pend_q, exit_pend_d;
  logic                deny_q, deny_d;

  logic [1:0]          entry_sh_q, exit_sh_q;
  logic                entry_lvl_q, exit_lvl_q;

  logic                entry_lvl, exit_lvl;
  logic                entry_req, exit_req;
  logic                entry_avail, exit_avail;
  logic                lot_full;

  // Two-stage debounce; a request is the rising edge of the debounced level.
  assign entry_lvl   = &entry_sh_q;
  assign exit_lvl    = &exit_sh_q;
  assign entry_req   = entry_lvl & ~entry_lvl_q;
  assign exit_req    = exit_lvl  & ~exit_lvl_q;
  assign entry_avail = entry_req | entry_pend_q;
  assign exit_avail  = exit_req  | exit_pend_q;
  assign lot_full    = (occ_q == CAP);

  always_ff @(posedge clk_2Hz) begin
    if (!reset) begin
      entry_sh_q  <= 2'b00;
      exit_sh_q   <= 2'b00;
      entry_lvl_q <= 1'b0;
      exit_lvl_q  <= 1'b0;
    end else begin
      entry_sh_q  <= {entry_sh_q[0], entry_sensor};
      exit_sh_q   <= {exit_sh_q[0], exit_sensor};
      entry_lvl_q <= entry_lvl;
      exit_lvl_q  <= exit_lvl;
    end
  end

  always_ff @(posedge clk_2Hz) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      occ_q        <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      deny_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      occ_q        <= occ_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      deny_q       <= deny_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    occ_d        = occ_q;
    entry_pend_d = entry_pend_q;
    exit_pend_d  = exit_pend_q;
    deny_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (exit_avail && (occ_q != '0)) begin
          // Exit wins arbitration since it frees a slot.
          occ_d       = (occ_q != '0) ? occ_q - 1'b1 : occ_q;
          state_d     = ST_GRANT;
          exit_pend_d = 1'b0;
`ifdef PARKING_PENDING_EN
          if (entry_req) begin
            entry_pend_d = 1'b1;
          end
`endif
        end else begin
          exit_pend_d = 1'b0;
          if (entry_avail) begin
            entry_pend_d = 1'b0;
            if (!lot_full) begin
              occ_d   = (occ_q < CAP) ? occ_q + 1'b1 : occ_q;
              state_d = ST_GRANT;
            end else begin
              deny_d = 1'b1;
            end
          end
        end
      end

      ST_GRANT: begin
        hold_d  = '0;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PARKING_PENDING_EN
    // Requests arriving while the door is busy are parked until the next IDLE.
    if (state_q != ST_IDLE) begin
      if (entry_req) begin
        entry_pend_d = 1'b1;
      end
      if (exit_req) begin
        exit_pend_d = 1'b1;
      end
    end
`endif
  end

  assign open_signal = (state_q == ST_GRANT);
  assign busy        = (state_q != ST_IDLE);
  assign deny        = deny_q;
  assign full        = lot_full;
  assign occupied    = occ_q;
  assign free_slots  = CAP - occ_q;

endmodule

`default_nettype wire
